vx_decode_queue: RTL and testbench
==================================

VX_DECODE_QUEUE -- requirements
Module: VX_decode_queue

Interface
REQ-001 SHALL take parameter DATAW, default 128: width of the packed decode payload (uuid, tmask, PC, ex_type, op_type, op_mod, wb, use_PC, use_imm, imm, rd, rs1-rs3, func3, func7).
REQ-002 SHALL take parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 SHALL take parameter NUM_WARPS, default 4: number of warps tracked; NWB = max(1, clog2(NUM_WARPS)).
REQ-004 SHALL take parameter BYPASS, default 0: 1 = zero-latency pass-through when empty; 0 = registered output, minimum latency 1 cycle.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-008 SHALL have port valid_in, input, 1 bit: upstream decode has an entry.
REQ-009 SHALL have port wid_in, input, NWB bits: warp id of the incoming entry.
REQ-010 SHALL have port data_in, input, DATAW bits: incoming payload.
REQ-011 SHALL have port ready_in, output, 1 bit: queue accepts an entry this cycle.
REQ-012 SHALL have port valid_out, output, 1 bit: head entry is valid.
REQ-013 SHALL have port wid_out, output, NWB bits: warp id of the head entry.
REQ-014 SHALL have port data_out, output, DATAW bits: head payload.
REQ-015 SHALL have port ready_out, input, 1 bit: downstream accepts the head entry.
REQ-016 SHALL have port count, output, clog2(DEPTH+1) bits: number of stored entries.
REQ-017 SHALL have port warp_pending, output, NUM_WARPS bits: bit w = 1 iff at least one stored entry has wid w.

Function
REQ-018 SHALL push on valid_in && ready_in and pop on valid_out && ready_out; both may occur in the same cycle.
REQ-019 SHALL drive ready_in = (count < DEPTH) || (valid_out && ready_out), allowing a push while full when a pop occurs in the same cycle; ready_in SHALL NOT depend combinationally on valid_in.
REQ-020 SHALL implement the storage as a circular buffer with rd_ptr and wr_ptr of clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-021 SHALL derive count from an explicit counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL, when BYPASS=1 and count==0, drive valid_out=valid_in, data_out=data_in and wid_out=wid_in combinationally; a same-cycle consumption SHALL NOT write the entry into storage.
REQ-023 SHALL, when BYPASS=0, make a pushed entry visible on valid_out no earlier than the next cycle.
REQ-024 SHALL preserve FIFO order across all warps; entries are never reordered.
REQ-025 SHALL keep one pending counter per warp, clog2(DEPTH+1) bits: +1 on push of wid w, -1 on pop of wid w, net 0 when both hit the same w in one cycle; warp_pending[w] = (counter w != 0).
REQ-026 SHALL, on flush=1, make the next state count=0, rd_ptr=wr_ptr=0 and all pending counters 0, ignoring any same-cycle push.
REQ-027 SHALL force ready_in=0 and valid_out=0 during a flush cycle, including in the BYPASS=1 path.
REQ-028 SHALL hold data_out and wid_out stable while valid_out=1 && ready_out=0.
REQ-029 SHALL NOT change state on push when full with no pop, or on pop when empty; both are prevented by the handshake.

Reset
REQ-030 SHALL, while reset=0 (asynchronously), clear count, rd_ptr, wr_ptr and all pending counters, and drive valid_out=0 and warp_pending=0.
REQ-031 SHALL drive ready_in=1 in the first cycle after reset deasserts.
REQ-032 SHALL leave payload storage unreset; data_out is don't-care while valid_out=0.
REQ-033 SHALL, on reset asserted mid-operation, drop all entries immediately and discard any in-flight handshake in that cycle.

Verification
REQ-034 SHALL cover fill then drain with DEPTH=4, BYPASS=0: push wid 0,1,2,3 with ready_out=0 -> count=4, ready_in=0, warp_pending=4'b1111; then ready_out=1 -> outputs in order 0,1,2,3, count returns to 0.
REQ-035 SHALL cover simultaneous push and pop while full: push wid 2 and pop wid 0 in one cycle -> count stays 4, warp_pending[0] clears, warp_pending[2] set, order preserved.
REQ-036 SHALL cover BYPASS=1 with the queue empty and ready_out=1: valid_in with data 0xA5 -> data_out=0xA5 in the same cycle and count remains 0.
REQ-037 SHALL cover flush with 3 entries stored and valid_in=1 -> next cycle count=0, warp_pending=0, and the pushed entry is absent.
REQ-038 SHALL cover pointer wrap-around: run 10 push/pop pairs with DEPTH=4 -> data integrity holds and count never exceeds 4.
REQ-039 SHALL cover reset asserted mid-stream with count=2 -> valid_out=0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vx_decode_queue.sv
// Decode-to-issue staging FIFO with per-warp occupancy tracking.
// With BYPASS=1 an empty queue hands the incoming entry straight to the output.
module vx_decode_queue #(
  parameter int DATAW     = 128,
  parameter int DEPTH     = 4,
  parameter int NUM_WARPS = 4,
  parameter int BYPASS    = 0,
  localparam int NWB      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [NWB-1:0]       wid_in,
  input  logic [DATAW-1:0]     data_in,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic [NWB-1:0]       wid_out,
  output logic [DATAW-1:0]     data_out,
  input  logic                 ready_out,
  output logic [CW-1:0]        count,
  output logic [NUM_WARPS-1:0] warp_pending
);

  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [NWB+DATAW-1:0] mem [DEPTH];
  logic                 stored, thru, do_push, do_pop, wr_en, rd_en;

  assign stored = (count != '0);

  if (BYPASS != 0) begin : g_byp
    assign valid_out          = !flush && (stored || valid_in);
    assign {wid_out, data_out} = stored ? mem[rd_ptr] : {wid_in, data_in};
    assign thru               = !stored;
  end else begin : g_reg
    assign valid_out          = !flush && stored;
    assign {wid_out, data_out} = mem[rd_ptr];
    assign thru               = 1'b0;
  end

  // Uses the stored-entry view of the pop so ready_in never sees valid_in.
  assign ready_in = !flush && ((count != CW'(DEPTH)) || (stored && ready_out));
  assign do_push  = valid_in && ready_in;
  assign do_pop   = valid_out && ready_out;
  // A pass-through entry is consumed on arrival and never touches storage.
  assign wr_en    = do_push && !(thru && do_pop);
  assign rd_en    = do_pop && !thru;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wid_in, data_in};
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [CW-1:0] pend;
    logic          inc, dec;
    assign inc = do_push && (wid_in == NWB'(w));
    assign dec = do_pop && (wid_out == NWB'(w));
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)            pend <= '0;
      else if (flush)        pend <= '0;
      else if (inc && !dec)  pend <= pend + CW'(1);
      else if (dec && !inc)  pend <= pend - CW'(1);
    end
    assign warp_pending[w] = (pend != '0);
  end

endmodule

// File: tb/tb_vx_decode_queue.sv
// Directed + randomized bench: a registered-output queue checked against a
// queue-based reference model, plus directed checks on a pass-through instance.
module tb_vx_decode_queue;
  localparam int DW = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
  logic [1:0]    wid_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          ready_in, valid_out;
  logic [1:0]    wid_out;
  logic [DW-1:0] data_out;
  logic [2:0]    count;
  logic [3:0]    warp_pending;

  logic          b_flush = 1'b0, b_valid_in = 1'b0, b_ready_out = 1'b0;
  logic [1:0]    b_wid_in = '0;
  logic [DW-1:0] b_data_in = '0;
  logic          b_ready_in, b_valid_out;
  logic [1:0]    b_wid_out;
  logic [DW-1:0] b_data_out;
  logic [2:0]    b_count;
  logic [3:0]    b_warp_pending;

  vx_decode_queue #(.DATAW(DW), .DEPTH(DEPTH), .NUM_WARPS(4), .BYPASS(0)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .wid_in(wid_in),
    .data_in(data_in), .ready_in(ready_in), .valid_out(valid_out), .wid_out(wid_out),
    .data_out(data_out), .ready_out(ready_out), .count(count), .warp_pending(warp_pending));

  vx_decode_queue #(.DATAW(DW), .DEPTH(DEPTH), .NUM_WARPS(4), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .flush(b_flush), .valid_in(b_valid_in), .wid_in(b_wid_in),
    .data_in(b_data_in), .ready_in(b_ready_in), .valid_out(b_valid_out), .wid_out(b_wid_out),
    .data_out(b_data_out), .ready_out(b_ready_out), .count(b_count), .warp_pending(b_warp_pending));

  int checks = 0, errors = 0;

  typedef struct { logic [1:0] wid; logic [DW-1:0] data; } ent_t;
  ent_t q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock of the registered queue: drive, check at negedge, advance the model.
  task automatic cycle(input logic v, input logic [1:0] w, input logic [DW-1:0] d,
                       input logic ro, input logic fl);
    logic       exp_vld, exp_rdy;
    logic [3:0] exp_pend;
    int         n;
    valid_in = v; wid_in = w; data_in = d; ready_out = ro; flush = fl;
    @(negedge clk);
    n        = q.size();
    exp_vld  = (n > 0) && !fl;
    exp_rdy  = !fl && ((n < DEPTH) || (exp_vld && ro));
    exp_pend = '0;
    foreach (q[i]) exp_pend[q[i].wid] = 1'b1;
    chk("valid_out", valid_out, exp_vld);
    chk("ready_in", ready_in, exp_rdy);
    chk("count", count, n);
    chk("warp_pending", warp_pending, exp_pend);
    if (exp_vld) begin
      chk("wid_out", wid_out, q[0].wid);
      chk("data_out", data_out, q[0].data);
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (exp_vld && ro) void'(q.pop_front());
      if (v && exp_rdy) q.push_back('{w, d});
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_pending", warp_pending, 4'b0);
    chk("rst_b_count", b_count, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);

    // pass-through instance: same-cycle hand-off, no storage write
    b_valid_in = 1'b1; b_wid_in = 2'd1; b_data_in = 128'hA5; b_ready_out = 1'b1;
    #1;
    chk("byp_valid", b_valid_out, 1'b1);
    chk("byp_data", b_data_out, 128'hA5);
    chk("byp_wid", b_wid_out, 2'd1);
    chk("byp_ready_in", b_ready_in, 1'b1);
    @(posedge clk); #1 b_valid_in = 1'b0; #1;
    chk("byp_count", b_count, 0);
    chk("byp_idle_valid", b_valid_out, 1'b0);
    chk("byp_pending", b_warp_pending, 4'b0);
    b_valid_in = 1'b1; b_wid_in = 2'd3; b_data_in = 128'h3C; b_ready_out = 1'b0;
    #1;
    chk("byp_stall_data", b_data_out, 128'h3C);
    @(posedge clk); #1 b_valid_in = 1'b0; b_data_in = 128'hFF; #1;
    chk("byp_stored_count", b_count, 1);
    chk("byp_stored_valid", b_valid_out, 1'b1);
    chk("byp_stored_data", b_data_out, 128'h3C);
    chk("byp_stored_pending", b_warp_pending, 4'b1000);
    b_ready_out = 1'b1;
    @(posedge clk); #1;
    chk("byp_drain_count", b_count, 0);
    b_valid_in = 1'b1; b_flush = 1'b1; #1;
    chk("byp_flush_valid", b_valid_out, 1'b0);
    chk("byp_flush_ready", b_ready_in, 1'b0);
    @(posedge clk); #1 b_flush = 1'b0; b_valid_in = 1'b0; #1;
    chk("byp_flush_count", b_count, 0);

    // fill, then swap while full, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), rnd(), 1'b0, 1'b0);
    valid_in = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_ready_in", ready_in, 1'b0);
    chk("fill_pending", warp_pending, 4'b1111);
    cycle(1'b1, 2'd2, rnd(), 1'b1, 1'b0);
    valid_in = 1'b0; ready_out = 1'b0; #1;
    chk("swap_count", count, 4);
    chk("swap_pending", warp_pending, 4'b1110);
    chk("swap_head_wid", wid_out, 2'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drain_count", count, 0);

    // wrap-around with paired push/pop
    cycle(1'b1, 2'($urandom_range(0, 3)), rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), rnd(), 1'b1, 1'b0);
      chk("wrap_count_le_depth", count <= 3'd4, 1'b1);
    end
    cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // flush with 3 stored and a concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i + 1), rnd(), 1'b0, 1'b0);
    cycle(1'b1, 2'd0, rnd(), 1'b0, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_pending", warp_pending, 4'b0);
    cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));

    // asynchronous reset mid-stream
    cycle(1'b0, 2'd0, '0, 1'b0, 1'b1);
    cycle(1'b1, 2'd1, rnd(), 1'b0, 1'b0);
    cycle(1'b1, 2'd2, rnd(), 1'b0, 1'b0);
    valid_in = 1'b0;
    chk("pre_reset_count", count, 2);
    reset = 1'b0; #1;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_pending", warp_pending, 4'b0);
    q.delete();
    @(posedge clk); #1 reset = 1'b1;
    cycle(1'b0, 2'd0, '0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, rnd(), 1'b0, 1'b0);
    cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
